dds_port_rx: RTL and testbench
==============================

DDS_PORT_RX -- requirements
Module: dds_port_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for asynchronous port inputs (legal 2..4).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETN  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports WRITE  input  1  parallel-port write strobe (asynchronous); AIN  input  5  register address; DIN  input  8  register data.
REQ-005 SHALL have ports UDCLK  input  1  update clock (asynchronous); DDSRESET  input  1  device master reset, active-high level (asynchronous).
REQ-006 SHALL have outputs FTW1, FTW2  output  48  active frequency tuning words; DFW  output  48  active delta-frequency word.
REQ-007 SHALL have outputs PTW1, PTW2  output  14  active phase words; RAMPRATE  output  20  active ramp rate.
REQ-008 SHALL have outputs MODE  output  3; TRIANGLE  output  1; PLLEN  output  1; PLLRANGE  output  1; CLKMULT  output  5 (all active-bank values).
REQ-009 SHALL have outputs UPDATED  output  1  one-cycle pulse on transfer; ADDRERR  output  1  one-cycle pulse on write to unmapped address.

Function
REQ-010 SHALL pass WRITE, UDCLK and DDSRESET through SYNC_STAGES flops before use; a rising edge is detected when the last stage is 1 and the previous-cycle value was 0.
REQ-011 SHALL, on detected WRITE rising edge, capture AIN/DIN (sampled at the edge-detect cycle) into the buffer bank; latency strobe-to-buffer is SYNC_STAGES+1 cycles.
REQ-012 SHALL use address map (byte -> field): 0x00 PTW1[13:8] (DIN[5:0]), 0x01 PTW1[7:0], 0x02 PTW2[13:8], 0x03 PTW2[7:0], 0x04..0x09 FTW1[47:40]..[7:0], 0x0A..0x0F FTW2[47:40]..[7:0], 0x10..0x15 DFW[47:40]..[7:0], 0x1A RAMPRATE[19:16] (DIN[3:0]), 0x1B RAMPRATE[15:8], 0x1C RAMPRATE[7:0].
REQ-013 SHALL decode 0x1E as DIN[6]=PLLRANGE, DIN[5]=PLLEN, DIN[4:0]=CLKMULT; 0x1F as DIN[6:4]=MODE, DIN[2]=TRIANGLE; other DIN bits ignored.
REQ-014 SHALL treat 0x16..0x19 and 0x1D as unmapped: no buffer change, ADDRERR pulses one cycle.
REQ-015 SHALL keep all outputs unchanged by buffer writes until an update transfer.
REQ-016 SHALL, on detected UDCLK rising edge, copy the full buffer bank to the active outputs and pulse UPDATED in the same cycle the outputs change.
REQ-017 SHALL, when WRITE and UDCLK edges are detected in the same cycle, include that write in the transferred values.
REQ-018 SHALL, while synchronized DDSRESET is high, hold buffer and active banks at defaults (all zero), ignore WRITE and UDCLK edges, and keep UPDATED/ADDRERR low.
REQ-019 SHALL write each buffer byte independently; repeated writes to one address keep the last value.

Reset
REQ-020 SHALL, with RESETN low at a CLK edge, clear buffer bank, active bank, synchronizer and edge-history flops; all outputs 0 next cycle.
REQ-021 SHALL, on reset mid-sequence, discard all partially written buffer bytes; no edge is detected on the first cycle after release.

Configuration
REQ-022 SHALL, with macro DDS_PORT_RX_READBACK_EN defined, add ports RDADDR  input  5 and RDDATA  output  8 returning the buffer byte at RDADDR (same bit packing as REQ-012/013, unused bits 0, unmapped reads 0) one cycle later.
REQ-023 SHALL, without DDS_PORT_RX_READBACK_EN, omit RDADDR/RDDATA and all readback logic.

Structure
REQ-024 SHALL place address constants, MODE encodings (000 single tone, 001 FSK, 010 ramped FSK, 011 chirp, 100 BPSK) and bank default values in shared package dds_port_pkg.
REQ-025 SHALL instantiate sub-module dds_edge_sync (synchronizer plus rising-edge detect) once per WRITE, UDCLK and DDSRESET.

Verification
REQ-026 SHALL cover: write 0x04..0x09 = 12,34,56,78,9A,BC then UDCLK -> FTW1=0x123456789ABC, UPDATED one pulse, outputs unchanged before UDCLK.
REQ-027 SHALL cover: write 0x1F=0x24, 0x1E=0x64 then UDCLK -> MODE=010, TRIANGLE=1, PLLRANGE=1, PLLEN=1, CLKMULT=4.
REQ-028 SHALL cover: write 0x17=0xFF -> ADDRERR one pulse, readback of all mapped bytes unchanged, outputs unchanged.
REQ-029 SHALL cover: WRITE 0x1C=0x55 and UDCLK rising in same CLK cycle -> RAMPRATE[7:0]=0x55 after transfer.
REQ-030 SHALL cover: DDSRESET high after loading FTW2=0xFFFFFFFFFFFF -> all outputs 0, WRITE/UDCLK ignored until DDSRESET low.
REQ-031 SHALL cover: RESETN low between 0x00 and 0x01 writes -> after release 0x01 write plus UDCLK gives PTW1=0x00xx with upper bits 0.

Source files
------------

// File: rtl/dds_port_pkg.sv
// dds_port_pkg -- shared definitions for the DDS parallel-port receiver.
//
// Purpose : register address map, MODE encodings, the buffer/active bank
//           layout with its default value, and helpers that apply a byte
//           write to a bank or read one mapped byte back from it.
// Ports   : none (package).
package dds_port_pkg;

    // Parallel-port byte addresses
    localparam logic [4:0] ADDR_PTW1_HI  = 5'h00;
    localparam logic [4:0] ADDR_PTW1_LO  = 5'h01;
    localparam logic [4:0] ADDR_PTW2_HI  = 5'h02;
    localparam logic [4:0] ADDR_PTW2_LO  = 5'h03;
    localparam logic [4:0] ADDR_FTW1_0   = 5'h04;  // FTW1[47:40]
    localparam logic [4:0] ADDR_FTW1_5   = 5'h09;  // FTW1[7:0]
    localparam logic [4:0] ADDR_FTW2_0   = 5'h0A;
    localparam logic [4:0] ADDR_FTW2_5   = 5'h0F;
    localparam logic [4:0] ADDR_DFW_0    = 5'h10;
    localparam logic [4:0] ADDR_DFW_5    = 5'h15;
    localparam logic [4:0] ADDR_GAP_LO   = 5'h16;  // 0x16..0x19 unmapped
    localparam logic [4:0] ADDR_GAP_HI   = 5'h19;
    localparam logic [4:0] ADDR_RAMP_HI  = 5'h1A;
    localparam logic [4:0] ADDR_RAMP_MID = 5'h1B;
    localparam logic [4:0] ADDR_RAMP_LO  = 5'h1C;
    localparam logic [4:0] ADDR_RSVD     = 5'h1D;  // unmapped
    localparam logic [4:0] ADDR_PLL      = 5'h1E;
    localparam logic [4:0] ADDR_MODE     = 5'h1F;

    typedef enum logic [2:0] {
        MODE_SINGLE_TONE = 3'b000,
        MODE_FSK         = 3'b001,
        MODE_RAMPED_FSK  = 3'b010,
        MODE_CHIRP       = 3'b011,
        MODE_BPSK        = 3'b100
    } mode_e;

    // One register bank. MODE is kept as raw bits: the port can write any
    // 3-bit value and the bank must reflect it verbatim.
    typedef struct packed {
        logic [13:0] ptw1;
        logic [13:0] ptw2;
        logic [47:0] ftw1;
        logic [47:0] ftw2;
        logic [47:0] dfw;
        logic [19:0] ramprate;
        logic [2:0]  mode;
        logic        triangle;
        logic        pllen;
        logic        pllrange;
        logic [4:0]  clkmult;
    } bank_t;

    localparam bank_t BANK_DEFAULT = '0;

    function automatic logic in_range(input logic [4:0] a,
                                      input logic [4:0] lo,
                                      input logic [4:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic logic addr_mapped(input logic [4:0] a);
        return !(in_range(a, ADDR_GAP_LO, ADDR_GAP_HI) || (a == ADDR_RSVD));
    endfunction

    // Byte index 0..5 inside a 48-bit word, 0 being the most significant byte.
    function automatic logic [2:0] byte_idx(input logic [4:0] a,
                                            input logic [4:0] base);
        logic [4:0] off;
        off = a - base;
        return off[2:0];
    endfunction

    function automatic logic [47:0] set_byte48(input logic [47:0] w,
                                               input logic [2:0]  idx,
                                               input logic [7:0]  d);
        logic [47:0] r;
        r = w;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) r[47-8*i -: 8] = d;
        end
        return r;
    endfunction

    function automatic logic [7:0] get_byte48(input logic [47:0] w,
                                              input logic [2:0]  idx);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) r = w[47-8*i -: 8];
        end
        return r;
    endfunction

    // Apply one port write to a bank; unmapped addresses leave it untouched.
    function automatic bank_t bank_write(input bank_t      b,
                                         input logic [4:0] a,
                                         input logic [7:0] d);
        bank_t r;
        r = b;
        if (in_range(a, ADDR_FTW1_0, ADDR_FTW1_5)) begin
            r.ftw1 = set_byte48(b.ftw1, byte_idx(a, ADDR_FTW1_0), d);
        end else if (in_range(a, ADDR_FTW2_0, ADDR_FTW2_5)) begin
            r.ftw2 = set_byte48(b.ftw2, byte_idx(a, ADDR_FTW2_0), d);
        end else if (in_range(a, ADDR_DFW_0, ADDR_DFW_5)) begin
            r.dfw = set_byte48(b.dfw, byte_idx(a, ADDR_DFW_0), d);
        end else begin
            case (a)
                ADDR_PTW1_HI:  r.ptw1[13:8]      = d[5:0];
                ADDR_PTW1_LO:  r.ptw1[7:0]       = d;
                ADDR_PTW2_HI:  r.ptw2[13:8]      = d[5:0];
                ADDR_PTW2_LO:  r.ptw2[7:0]       = d;
                ADDR_RAMP_HI:  r.ramprate[19:16] = d[3:0];
                ADDR_RAMP_MID: r.ramprate[15:8]  = d;
                ADDR_RAMP_LO:  r.ramprate[7:0]   = d;
                ADDR_PLL: begin
                    r.pllrange = d[6];
                    r.pllen    = d[5];
                    r.clkmult  = d[4:0];
                end
                ADDR_MODE: begin
                    r.mode     = d[6:4];
                    r.triangle = d[2];
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    // Read one byte back in the same packing used for writes; bits with no
    // storage and unmapped addresses read as 0.
    function automatic logic [7:0] bank_read(input bank_t      b,
                                             input logic [4:0] a);
        logic [7:0] r;
        r = '0;
        if (in_range(a, ADDR_FTW1_0, ADDR_FTW1_5)) begin
            r = get_byte48(b.ftw1, byte_idx(a, ADDR_FTW1_0));
        end else if (in_range(a, ADDR_FTW2_0, ADDR_FTW2_5)) begin
            r = get_byte48(b.ftw2, byte_idx(a, ADDR_FTW2_0));
        end else if (in_range(a, ADDR_DFW_0, ADDR_DFW_5)) begin
            r = get_byte48(b.dfw, byte_idx(a, ADDR_DFW_0));
        end else begin
            case (a)
                ADDR_PTW1_HI:  r = {2'b00, b.ptw1[13:8]};
                ADDR_PTW1_LO:  r = b.ptw1[7:0];
                ADDR_PTW2_HI:  r = {2'b00, b.ptw2[13:8]};
                ADDR_PTW2_LO:  r = b.ptw2[7:0];
                ADDR_RAMP_HI:  r = {4'b0000, b.ramprate[19:16]};
                ADDR_RAMP_MID: r = b.ramprate[15:8];
                ADDR_RAMP_LO:  r = b.ramprate[7:0];
                ADDR_PLL:      r = {1'b0, b.pllrange, b.pllen, b.clkmult};
                ADDR_MODE:     r = {1'b0, b.mode, 1'b0, b.triangle, 2'b00};
                default:       r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/dds_edge_sync.sv
// dds_edge_sync -- multi-flop synchronizer with rising-edge detect.
//
// Purpose : brings one asynchronous level into the clk_i domain and flags
//           the cycle in which its synchronized value goes 0 -> 1.
// Ports   : clk_i    clock
//           rst_n_i  synchronous active-low reset (clears chain and history)
//           async_i  asynchronous input level
//           level_o  synchronized level (last chain stage)
//           rise_o   one-cycle rising-edge indication (combinational)
module dds_edge_sync #(
    parameter int SYNC_STAGES = 2   // legal 2..4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History resets to 0 together with the chain, so the first cycle after
    // reset release can never report an edge.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/dds_port_rx.sv
// dds_port_rx -- DDS parallel-port register receiver.
//
// Purpose : byte writes from an asynchronous parallel port land in a buffer
//           bank; an asynchronous update clock copies the whole buffer bank
//           to the active bank driving the outputs. DDSRESET (async level)
//           holds both banks at their defaults.
// Ports   : CLK, RESETN (sync, active-low)
//           WRITE, AIN[4:0], DIN[7:0]   port write strobe, address, data
//           UDCLK                       update (transfer) strobe
//           DDSRESET                    device reset level, active-high
//           FTW1/FTW2/DFW[47:0], PTW1/PTW2[13:0], RAMPRATE[19:0],
//           MODE[2:0], TRIANGLE, PLLEN, PLLRANGE, CLKMULT[4:0]  active bank
//           UPDATED   one-cycle pulse when the active bank is loaded
//           ADDRERR   one-cycle pulse on a write to an unmapped address
// Config  : define DDS_PORT_RX_READBACK_EN to add RDADDR[4:0] / RDDATA[7:0],
//           a registered readback of the buffer bank (one-cycle latency).
module dds_port_rx
    import dds_port_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal 2..4
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        WRITE,
    input  logic [4:0]  AIN,
    input  logic [7:0]  DIN,
    input  logic        UDCLK,
    input  logic        DDSRESET,
    output logic [47:0] FTW1,
    output logic [47:0] FTW2,
    output logic [47:0] DFW,
    output logic [13:0] PTW1,
    output logic [13:0] PTW2,
    output logic [19:0] RAMPRATE,
    output logic [2:0]  MODE,
    output logic        TRIANGLE,
    output logic        PLLEN,
    output logic        PLLRANGE,
    output logic [4:0]  CLKMULT,
    output logic        UPDATED,
    output logic        ADDRERR
`ifdef DDS_PORT_RX_READBACK_EN
    ,
    input  logic [4:0]  RDADDR,
    output logic [7:0]  RDDATA
`endif
);

    logic wr_lvl, wr_rise;
    logic ud_lvl, ud_rise;
    logic drst_lvl, drst_rise;

    dds_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_write (
        .clk_i   (CLK),
        .rst_n_i (RESETN),
        .async_i (WRITE),
        .level_o (wr_lvl),
        .rise_o  (wr_rise)
    );

    dds_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udclk (
        .clk_i   (CLK),
        .rst_n_i (RESETN),
        .async_i (UDCLK),
        .level_o (ud_lvl),
        .rise_o  (ud_rise)
    );

    dds_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ddsreset (
        .clk_i   (CLK),
        .rst_n_i (RESETN),
        .async_i (DDSRESET),
        .level_o (drst_lvl),
        .rise_o  (drst_rise)
    );

    // Strobes act on edges only and DDSRESET acts on its level.
    logic unused_sync;
    assign unused_sync = wr_lvl ^ ud_lvl ^ drst_rise;

    bank_t shadow_q, shadow_d;
    bank_t active_q, active_d;
    logic  updated_q, updated_d;
    logic  addrerr_q, addrerr_d;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        updated_d = 1'b0;
        addrerr_d = 1'b0;
        if (drst_lvl) begin
            shadow_d = BANK_DEFAULT;
            active_d = BANK_DEFAULT;
        end else begin
            if (wr_rise) begin
                if (addr_mapped(AIN)) begin
                    shadow_d = bank_write(shadow_q, AIN, DIN);
                end else begin
                    addrerr_d = 1'b1;
                end
            end
            // Transfer the post-write buffer so a write detected in the same
            // cycle as the update is included.
            if (ud_rise) begin
                active_d  = shadow_d;
                updated_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            shadow_q  <= BANK_DEFAULT;
            active_q  <= BANK_DEFAULT;
            updated_q <= 1'b0;
            addrerr_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            updated_q <= updated_d;
            addrerr_q <= addrerr_d;
        end
    end

    assign FTW1     = active_q.ftw1;
    assign FTW2     = active_q.ftw2;
    assign DFW      = active_q.dfw;
    assign PTW1     = active_q.ptw1;
    assign PTW2     = active_q.ptw2;
    assign RAMPRATE = active_q.ramprate;
    assign MODE     = active_q.mode;
    assign TRIANGLE = active_q.triangle;
    assign PLLEN    = active_q.pllen;
    assign PLLRANGE = active_q.pllrange;
    assign CLKMULT  = active_q.clkmult;
    assign UPDATED  = updated_q;
    assign ADDRERR  = addrerr_q;

`ifdef DDS_PORT_RX_READBACK_EN
    logic [7:0] rddata_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rddata_q <= '0;
        end else begin
            rddata_q <= bank_read(shadow_q, RDADDR);
        end
    end

    assign RDDATA = rddata_q;
`endif

endmodule

// File: tb/tb_dds_port_rx.sv
module tb_dds_port_rx;

    localparam int S = 2;

    logic        CLK = 1'b0;
    logic        RESETN, WRITE, UDCLK, DDSRESET;
    logic [4:0]  AIN;
    logic [7:0]  DIN;
    logic [47:0] FTW1, FTW2, DFW;
    logic [13:0] PTW1, PTW2;
    logic [19:0] RAMPRATE;
    logic [2:0]  MODE;
    logic        TRIANGLE, PLLEN, PLLRANGE;
    logic [4:0]  CLKMULT;
    logic        UPDATED, ADDRERR;
`ifdef DDS_PORT_RX_READBACK_EN
    logic [4:0]  RDADDR;
    logic [7:0]  RDDATA;
`endif

    always #5 CLK = ~CLK;

    dds_port_rx #(.SYNC_STAGES(S)) dut (
        .CLK(CLK), .RESETN(RESETN), .WRITE(WRITE), .AIN(AIN), .DIN(DIN),
        .UDCLK(UDCLK), .DDSRESET(DDSRESET),
        .FTW1(FTW1), .FTW2(FTW2), .DFW(DFW), .PTW1(PTW1), .PTW2(PTW2),
        .RAMPRATE(RAMPRATE), .MODE(MODE), .TRIANGLE(TRIANGLE), .PLLEN(PLLEN),
        .PLLRANGE(PLLRANGE), .CLKMULT(CLKMULT), .UPDATED(UPDATED),
        .ADDRERR(ADDRERR)
`ifdef DDS_PORT_RX_READBACK_EN
        , .RDADDR(RDADDR), .RDDATA(RDDATA)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Model: the register file seen as 32 bytes. Each address keeps only the
    // bits that have storage; outputs are concatenations of those bytes.
    typedef struct {
        int         cyc;
        int         kind;   // 0 DDSRESET off, 1 write, 2 update, 3 DDSRESET on
        logic [4:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] shadow[32];
    logic [7:0] active[32];
    bit         dr_on;
    int         cyc = 0;
    logic       exp_upd = 1'b0, exp_aerr = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    function automatic logic [7:0] byte_mask(input logic [4:0] a);
        case (a)
            5'h00, 5'h02:                        return 8'h3F;
            5'h16, 5'h17, 5'h18, 5'h19, 5'h1D:   return 8'h00;
            5'h1A:                               return 8'h0F;
            5'h1E:                               return 8'h7F;
            5'h1F:                               return 8'h74;
            default:                             return 8'hFF;
        endcase
    endfunction

    function automatic logic [47:0] w48(input int base);
        return {active[base], active[base+1], active[base+2],
                active[base+3], active[base+4], active[base+5]};
    endfunction

    always @(posedge CLK) begin
        ev_t keep[$];
        cyc++;
        exp_upd  = 1'b0;
        exp_aerr = 1'b0;
`ifdef DDS_PORT_RX_READBACK_EN
        exp_rd = shadow[RDADDR];
`endif
        if (!RESETN) begin
            foreach (shadow[i]) begin shadow[i] = 8'h00; active[i] = 8'h00; end
            dr_on  = 1'b0;
            exp_rd = 8'h00;
            evq.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                foreach (evq[i]) begin
                    if (evq[i].cyc == cyc && evq[i].kind == k) begin
                        case (k)
                            0: dr_on = 1'b0;
                            1: if (!dr_on) begin
                                   if (byte_mask(evq[i].a) == 8'h00) exp_aerr = 1'b1;
                                   else shadow[evq[i].a] = evq[i].d & byte_mask(evq[i].a);
                               end
                            2: if (!dr_on) begin
                                   foreach (active[j]) active[j] = shadow[j];
                                   exp_upd = 1'b1;
                               end
                            default: begin
                                dr_on = 1'b1;
                                foreach (shadow[j]) begin shadow[j] = 8'h00; active[j] = 8'h00; end
                            end
                        endcase
                    end
                end
            end
            foreach (evq[i]) if (evq[i].cyc > cyc) keep.push_back(evq[i]);
            evq = keep;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        if (cyc >= 1) begin
            chk("FTW1", FTW1, w48(4));
            chk("FTW2", FTW2, w48(10));
            chk("DFW", DFW, w48(16));
            chk("PTW1", PTW1, {active[0][5:0], active[1]});
            chk("PTW2", PTW2, {active[2][5:0], active[3]});
            chk("RAMPRATE", RAMPRATE, {active[26][3:0], active[27], active[28]});
            chk("MODE", MODE, active[31][6:4]);
            chk("TRIANGLE", TRIANGLE, active[31][2]);
            chk("PLLRANGE", PLLRANGE, active[30][6]);
            chk("PLLEN", PLLEN, active[30][5]);
            chk("CLKMULT", CLKMULT, active[30][4:0]);
            chk("UPDATED", UPDATED, exp_upd);
            chk("ADDRERR", ADDRERR, exp_aerr);
`ifdef DDS_PORT_RX_READBACK_EN
            chk("RDDATA", RDDATA, exp_rd);
`endif
        end
    end

`ifdef DDS_PORT_RX_READBACK_EN
    initial begin
        RDADDR = 5'd0;
        forever begin
            @(negedge CLK);
            RDADDR = RDADDR + 5'd1;
        end
    end
`endif

    // Raise WRITE and/or UDCLK together, hold long enough for capture, then
    // drop and leave room for the next rising edge to be seen.
    task automatic strobe(input bit w, input bit u, input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        AIN = a;
        DIN = d;
        if (w) begin WRITE = 1'b1; evq.push_back('{cyc + 1 + S, 1, a, d}); end
        if (u) begin UDCLK = 1'b1; evq.push_back('{cyc + 1 + S, 2, a, d}); end
        repeat (S + 1) @(negedge CLK);
        WRITE = 1'b0;
        UDCLK = 1'b0;
        repeat (S + 1) @(negedge CLK);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        strobe(1'b1, 1'b0, a, d);
    endtask

    task automatic ud();
        strobe(1'b0, 1'b1, 5'd0, 8'd0);
    endtask

    task automatic drst(input bit v);
        @(negedge CLK);
        DDSRESET = v;
        evq.push_back('{cyc + 1 + S, v ? 3 : 0, 5'd0, 8'd0});
        repeat (S + 2) @(negedge CLK);
    endtask

    task automatic port_reset();
        @(negedge CLK);
        RESETN = 1'b0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ftw_bytes [6];
        ftw_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        RESETN = 1'b0; WRITE = 1'b0; UDCLK = 1'b0; DDSRESET = 1'b0;
        AIN = 5'd0; DIN = 8'd0;
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_FTW1", FTW1, 48'h0);
        chk("rst_MODE", MODE, 3'b000);

        // FTW1 byte-wise load, held back until the update strobe
        for (int i = 0; i < 6; i++) wr(5'(4 + i), ftw_bytes[i]);
        chk("preud_FTW1", FTW1, 48'h0);
        ud();
        chk("lit_FTW1", FTW1, 48'h123456789ABC);

        // Mode and PLL control bytes
        wr(5'h1F, 8'h24);
        wr(5'h1E, 8'h64);
        ud();
        chk("lit_MODE", MODE, 3'b010);
        chk("lit_TRIANGLE", TRIANGLE, 1'b1);
        chk("lit_PLLRANGE", PLLRANGE, 1'b1);
        chk("lit_PLLEN", PLLEN, 1'b1);
        chk("lit_CLKMULT", CLKMULT, 5'd4);

        // Phase words, DFW with a repeated write, ramp rate, masked bits
        wr(5'h00, 8'hFF);
        wr(5'h01, 8'h11);
        wr(5'h02, 8'hC5);
        wr(5'h03, 8'hA0);
        for (int i = 0; i < 6; i++) wr(5'(16 + i), 8'(8'h21 * (i + 1)));
        wr(5'h10, 8'hAA);
        wr(5'h10, 8'h5B);
        wr(5'h1A, 8'hFF);
        wr(5'h1B, 8'h12);
        wr(5'h1C, 8'h00);
        ud();
        chk("lit_PTW1", PTW1, 14'h3F11);
        chk("lit_PTW2", PTW2, 14'h05A0);
        chk("lit_DFW", DFW, 48'h5B426384A5C6);
        chk("lit_RAMP", RAMPRATE, 20'hF1200);

        // Unmapped addresses: ADDRERR only, buffer untouched
        wr(5'h17, 8'hFF);
        wr(5'h16, 8'h33);
        wr(5'h19, 8'h44);
        wr(5'h1D, 8'h55);
        repeat (34) @(negedge CLK);
        ud();
        chk("lit_FTW1_after_unmapped", FTW1, 48'h123456789ABC);

        // Write and update edges land in the same cycle
        strobe(1'b1, 1'b1, 5'h1C, 8'h55);
        chk("lit_RAMP_same", RAMPRATE, 20'hF1255);

        // Ignored MODE byte bits
        wr(5'h1F, 8'hFF);
        ud();
        chk("lit_MODE_ff", MODE, 3'b111);

        // DDSRESET clears both banks and blocks writes/updates
        for (int i = 0; i < 6; i++) wr(5'(10 + i), 8'hFF);
        ud();
        chk("lit_FTW2", FTW2, 48'hFFFFFFFFFFFF);
        drst(1'b1);
        repeat (2) @(negedge CLK);
        chk("drst_FTW2", FTW2, 48'h0);
        chk("drst_MODE", MODE, 3'b000);
        wr(5'h04, 8'h77);
        wr(5'h18, 8'h01);
        ud();
        chk("drst_FTW1", FTW1, 48'h0);
        drst(1'b0);
        ud();
        chk("post_drst_FTW1", FTW1, 48'h0);
        wr(5'h05, 8'h42);
        ud();
        chk("post_drst_wr", FTW1, 48'h004200000000);

        // RESETN between the two PTW1 bytes drops the first one
        wr(5'h00, 8'h3F);
        port_reset();
        chk("rst_mid_PTW1", PTW1, 14'h0);
        wr(5'h01, 8'hA5);
        ud();
        chk("lit_PTW1_rst", PTW1, 14'h00A5);

        repeat (4) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
